// File: rtl/mult_pkg.sv
// Shared multiply/divide definitions: FSM states, operand width and
// Booth recoding used by the sequential multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of {Q[0], q_1}
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        op = BOOTH_NOP;
        unique case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into acc, then an
// arithmetic right shift of {acc, Q, q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    booth_op_t      op;
    logic [WIDTH:0] sum;

    assign op = booth_decode(q[0], q_1);

    always_comb begin
        sum = acc;
        unique case (op)
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
    end

    assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/mult_seq.sv
// Sequential signed Booth multiplier, one step per clock, writing the
// 2*WIDTH-bit product into the hi/lo register pair.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multCtrl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             multBusy,
    output logic             multDone,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    mult_state_t      state;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [5:0]       count;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             q_1_next;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_next(acc_next),
        .q_next  (q_next),
        .q_1_next(q_1_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            multBusy <= 1'b0;
            multDone <= 1'b0;
        end else if (multCtrl) begin
            // A start in any state reloads; an in-flight product is dropped
            state    <= RUN;
            acc      <= '0;
            m        <= {srcA[WIDTH-1], srcA};
            q        <= srcB;
            q_1      <= 1'b0;
            count    <= '0;
            multBusy <= 1'b1;
            multDone <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    q_1   <= q_1_next;
                    count <= count + 6'd1;
                    if (count == LAST) begin
                        hi       <= acc_next[WIDTH-1:0];
                        lo       <= q_next;
                        multBusy <= 1'b0;
                        multDone <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    multDone <= 1'b0;
                    state    <= IDLE;
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    multBusy <= 1'b0;
                    multDone <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
